// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the push-button debouncers.
package debounce_pkg;

    localparam int DEB_STABLE_DEFAULT        = 50;
    localparam int DEB_REPEAT_DELAY_DEFAULT  = 500000;
    localparam int DEB_REPEAT_PERIOD_DEFAULT = 100000;

    // Counter width able to hold 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, stability counter, level and strobes.
// Auto-repeat of the press strobe exists only when MULTI_BTN_DEBOUNCE_REPEAT_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_STABLE_DEFAULT,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = DEB_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = DEB_REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_strobe,
    output logic press_nxt
);

    localparam int            CW       = clog2_min1(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          POL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic          sync1_r, sync2_r, level_r, press_r, release_r;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          level_nxt_s, press_acc_s, release_acc_s, rpt_fire_s, press_out_s;

    // Stability counter: any sample equal to the current level restarts the count.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        level_nxt_s   = level_r;
        press_acc_s   = 1'b0;
        release_acc_s = 1'b0;
        if (sync2_r == level_r) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_nxt_s     = {CW{1'b0}};
            level_nxt_s   = sync2_r;
            press_acc_s   = sync2_r;
            release_acc_s = ~sync2_r;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

`ifdef MULTI_BTN_DEBOUNCE_REPEAT_EN
    localparam int            RW          = clog2_min1(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] RPT_D_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_P_LAST  = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RPT_ONE     = RW'(1);

    logic [RW-1:0] rpt_cnt_r, rpt_cnt_nxt_s;
    logic          rpt_first_r, rpt_first_nxt_s;

    // Repeat timer: first interval is the delay, later ones the period; idle while released.
    always_comb begin
        rpt_cnt_nxt_s   = rpt_cnt_r;
        rpt_first_nxt_s = rpt_first_r;
        rpt_fire_s      = 1'b0;
        if (press_acc_s) begin
            rpt_cnt_nxt_s   = {RW{1'b0}};
            rpt_first_nxt_s = 1'b1;
        end else if (level_r && !release_acc_s) begin
            if (rpt_first_r && (rpt_cnt_r == RPT_D_LAST)) begin
                rpt_fire_s      = 1'b1;
                rpt_cnt_nxt_s   = {RW{1'b0}};
                rpt_first_nxt_s = 1'b0;
            end else if (!rpt_first_r && (rpt_cnt_r == RPT_P_LAST)) begin
                rpt_fire_s    = 1'b1;
                rpt_cnt_nxt_s = {RW{1'b0}};
            end else begin
                rpt_cnt_nxt_s = rpt_cnt_r + RPT_ONE;
            end
        end else begin
            rpt_cnt_nxt_s   = {RW{1'b0}};
            rpt_first_nxt_s = 1'b1;
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_r   <= {RW{1'b0}};
            rpt_first_r <= 1'b1;
        end else begin
            rpt_cnt_r   <= rpt_cnt_nxt_s;
            rpt_first_r <= rpt_first_nxt_s;
        end
    end
`else
    assign rpt_fire_s = 1'b0;
`endif

    assign press_out_s = press_acc_s | rpt_fire_s;

    // Synchroniser, level and strobe registers; sync flops reset to the released value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            sync1_r   <= raw ^ POL;
            sync2_r   <= sync1_r;
            cnt_r     <= cnt_nxt_s;
            level_r   <= level_nxt_s;
            press_r   <= press_out_s;
            release_r <= release_acc_s;
        end
    end

    assign level          = level_r;
    assign press          = press_r;
    assign release_strobe = release_r;
    assign press_nxt      = press_out_s & ~rst;

endmodule

// File: rtl/multi_btn_debounce.sv
// N-channel push-button debouncer with press/release strobes and a combined any_press.
// Optional auto-repeat of press is enabled by defining MULTI_BTN_DEBOUNCE_REPEAT_EN.
module multi_btn_debounce
    import debounce_pkg::*;
#(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = DEB_STABLE_DEFAULT,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = DEB_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = DEB_REPEAT_PERIOD_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_btn,
    output logic [N-1:0] out_btn,
    output logic [N-1:0] press,
    output logic [N-1:0] release_strobe,
    output logic         any_press
);

    logic [N-1:0] press_nxt_s;
    logic         any_press_r;

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .raw            (in_btn[i]),
            .level          (out_btn[i]),
            .press          (press[i]),
            .release_strobe (release_strobe[i]),
            .press_nxt      (press_nxt_s[i])
        );
    end

    // Registered from the channels' next-press terms so it lines up with press.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_press_r <= 1'b0;
        end else begin
            any_press_r <= |press_nxt_s;
        end
    end

    assign any_press = any_press_r;

endmodule

// File: tb/tb_multi_btn_debounce.sv
// Directed self-checking bench for multi_btn_debounce (N=4, STABLE_CYCLES=8, active-low pins).
// Repeat expectations follow whether MULTI_BTN_DEBOUNCE_REPEAT_EN is defined.
module tb_multi_btn_debounce;

`ifdef MULTI_BTN_DEBOUNCE_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in_btn = 4'hF;
    logic [3:0] out_btn, press, release_strobe;
    logic       any_press;

    int vectors = 0;
    int fails   = 0;

    multi_btn_debounce #(
        .N(4), .STABLE_CYCLES(8), .ACTIVE_LOW(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .rst(rst), .in_btn(in_btn), .out_btn(out_btn),
        .press(press), .release_strobe(release_strobe), .any_press(any_press)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                             input logic [3:0] rel, input logic anyp);
        check({tag, ".out_btn"}, out_btn, lvl);
        check({tag, ".press"}, press, prs);
        check({tag, ".release"}, release_strobe, rel);
        check({tag, ".any_press"}, {3'b000, any_press}, {3'b000, anyp});
    endtask

    initial begin
        logic [3:0] sticky_strobe;
        logic [3:0] exp_p;

        // Reset
        rst = 1'b1;
        step(2);
        check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        step(3);
        check_all("idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // 1: clean press on channel 0; level rises on edge 10
        in_btn = 4'b1110;
        step(9);
        check_all("press.e9", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(1);
        check_all("press.e10", 4'b0001, 4'b0001, 4'b0000, 1'b1);
        step(1);
        check_all("press.e11", 4'b0001, 4'b0000, 4'b0000, 1'b0);

        // 2: bounce on channel 1, toggling every 3 cycles
        sticky_strobe = 4'b0000;
        for (int c = 0; c < 40; c++) begin
            in_btn[1] = (((c / 3) % 2) == 0) ? 1'b0 : 1'b1;
            step(1);
            sticky_strobe = sticky_strobe | press | release_strobe | {3'b000, any_press};
        end
        in_btn[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step(1);
            sticky_strobe = sticky_strobe | press | release_strobe | {3'b000, any_press};
        end
        check("bounce.strobes", sticky_strobe, 4'b0000);
        check("bounce.out_btn", out_btn, 4'b0001);

        // 3: release channel 0
        in_btn[0] = 1'b1;
        step(9);
        check_all("rel.e9", 4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(1);
        check_all("rel.e10", 4'b0000, 4'b0000, 4'b0001, 1'b0);
        step(1);
        check_all("rel.e11", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // 4: simultaneous press and release of all channels
        in_btn = 4'b0000;
        step(10);
        check_all("sim.e10", 4'b1111, 4'b1111, 4'b0000, 1'b1);
        step(1);
        check_all("sim.e11", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        in_btn = 4'b1111;
        step(10);
        check_all("simrel.e10", 4'b0000, 4'b0000, 4'b1111, 1'b0);
        step(1);
        check_all("simrel.e11", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // 5: reset mid-count on channel 2 (count at 5 after 7 edges)
        in_btn = 4'b1011;
        step(7);
        rst = 1'b1;
        step(1);
        check_all("rst.mid", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        step(9);
        check_all("rst.e9", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(1);
        check_all("rst.e10", 4'b0100, 4'b0100, 4'b0000, 1'b1);
        in_btn = 4'b1111;
        step(11);
        check_all("rst.rel", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // 6: hold channel 0; repeats at t0+20,+25,+30,+35 only when compiled in
        in_btn = 4'b1110;
        step(10);
        check_all("rpt.t0", 4'b0001, 4'b0001, 4'b0000, 1'b1);
        sticky_strobe = 4'b0000;
        for (int k = 1; k <= 50; k++) begin
            step(1);
            exp_p = (RPT && (k == 20 || k == 25 || k == 30 || k == 35)) ? 4'b0001 : 4'b0000;
            if (press !== exp_p || {3'b000, any_press} !== exp_p) begin
                sticky_strobe = sticky_strobe | 4'b1000;
            end
            if (k == 20) begin
                check("rpt.k20", press, RPT ? 4'b0001 : 4'b0000);
            end
            if (k == 35) begin
                check("rpt.k35", {3'b000, any_press}, RPT ? 4'b0001 : 4'b0000);
            end
            if (k == 39) begin
                check("rpt.rel", release_strobe, 4'b0001);
            end
            if (k == 29) begin
                in_btn = 4'b1111;
            end
        end
        check("rpt.pattern", sticky_strobe, 4'b0000);
        check_all("rpt.end", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/multi_btn_debounce.md
# multi_btn_debounce

Parametrised N-channel push-button debouncer, the successor to the single-channel debouncer. It sits between the board's raw button pins and the game/control logic. Each channel gets:
- a two-flop synchroniser;
- a per-channel stability counter;
- a debounced level output;
- single-cycle press and release strobes;
- an optional auto-repeat of the press strobe while a button is held.

## Interface
- `N`, 4: channel count, ≥1.
- `STABLE_CYCLES`, 50: consecutive identical synchronised samples required to accept a new level, ≥1.
- `ACTIVE_LOW`, 1: 1 means a raw pin at 0 is "pressed"; 0 means a raw pin at 1 is "pressed".
- `REPEAT_DELAY`, 500000: cycles from the press strobe to the first repeat strobe, ≥1. Used only with repeat compiled in.
- `REPEAT_PERIOD`, 100000: cycles between subsequent repeat strobes, ≥1. Used only with repeat compiled in.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_btn` in N: raw asynchronous button pins.
- `out_btn` out N: debounced level; 1 = pressed, regardless of `ACTIVE_LOW`.
- `press` out N: one-cycle strobe on an accepted press, and on each auto-repeat.
- `release` out N: one-cycle strobe on an accepted release.
- `any_press` out 1: OR of `press`, registered in the same cycle as `press`.

## Operation
- **Polarity:** raw bit i is normalised to p = `in_btn[i]` XOR `ACTIVE_LOW`, so 1 = pressed. p passes through `sync1` and then `sync2`; `sync2` is the sample s.
- **Stability counter:** per channel, `cnt` of width `$clog2(STABLE_CYCLES+1)`.
  - If s == `out_btn[i]`: `cnt` ← 0.
  - Otherwise, if `cnt` == `STABLE_CYCLES-1`: `out_btn[i]` ← s, `cnt` ← 0, and pulse `press[i]` (if s = 1) or `release[i]` (if s = 0).
  - Otherwise: `cnt` ← `cnt`+1.
- **Bounce:** any sample equal to the current level restarts the count. A glitch shorter than `STABLE_CYCLES` samples never reaches the outputs.
- **Independence:** channels are fully independent. Simultaneous transitions on several channels each produce their own strobes in the same cycle.
- **Strobe ordering:** `press` and `release` are never both high on one channel in the same cycle.
- **No saturation:** `cnt` never exceeds `STABLE_CYCLES-1`.

## Timing
- **Reset values:**
  - `sync1` and `sync2` = 0, i.e. released after normalisation, so a held button at reset produces exactly one press after debounce.
  - `out_btn` = 0, `press` = 0, `release` = 0, `any_press` = 0.
  - All counters = 0.
- **Latency:** number edges from 1, where edge 1 is the first edge that samples the new, thereafter steady raw value.
  - `out_btn` changes on edge `STABLE_CYCLES+2`.
  - The strobe is high for the cycle immediately following that edge.
- **Strobes:** exactly one cycle wide. `any_press` is coincident with `press`.
- **Reset mid-operation:** on the edge where `rst` = 1, all state returns to the reset values. No strobe is emitted in the cycle after a reset edge.

## Configuration
- Macro: `MULTI_BTN_DEBOUNCE_REPEAT_EN`.
- **Defined:**
  - Each channel has a repeat counter, width `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)`. It clears on the press strobe and counts while `out_btn[i]` = 1.
  - When it reaches `REPEAT_DELAY` after the initial press, `press[i]` pulses. After that, it pulses every `REPEAT_PERIOD` cycles.
  - The repeat counter is cleared on release and on reset. A release strobe never coincides with a repeat strobe.
- **Undefined:** there is no repeat logic and no repeat counters. `press` fires only on accepted presses. `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Structure
- Shared package `debounce_pkg`:
  - `function clog2_min1`: counter width helper, returning ≥1.
  - Default constants `DEB_STABLE_DEFAULT`, `DEB_REPEAT_DELAY_DEFAULT`, `DEB_REPEAT_PERIOD_DEFAULT`.
- Sub-module `debounce_channel`:
  - Contains the synchroniser, stability counter, level register, strobes and optional repeat counter for one bit.
  - The top instantiates it N times in a generate loop and ORs the strobes into `any_press`.

## Test plan
1. **Clean press:** `N`=4, `STABLE_CYCLES`=8, `ACTIVE_LOW`=1. Drive `in_btn[0]` 1→0 and hold.
   - `out_btn[0]` rises after edge 10.
   - `press[0]` and `any_press` are high for exactly 1 cycle.
   - Other channels stay 0.
2. **Bounce rejection:** toggle `in_btn[1]` every 3 cycles for 40 cycles, then leave it high.
   - `out_btn[1]` stays 0.
   - No strobes occur.
3. **Release:** from the pressed state, set `in_btn[0]` to 1 and hold.
   - `out_btn[0]` falls after edge 10.
   - `release[0]` pulses once.
   - `press[0]` stays 0.
4. **Simultaneous press:** drive `in_btn[3:0]` 1111→0000 together.
   - All four `press` bits pulse in the same cycle.
   - `any_press` pulses once.
5. **Reset:** pulse `rst` mid-count (`cnt`=5), with `in_btn[2]` held low throughout.
   - All outputs are 0 in the cycle after reset.
   - The press is then accepted exactly `STABLE_CYCLES`+2 edges after `rst` deasserts.
6. **Auto-repeat:** define the macro with `REPEAT_DELAY`=20 and `REPEAT_PERIOD`=5, and hold a press for 40 cycles.
   - `press` pulses at t0, t0+20, t0+25, t0+30, t0+35.
   - No further `press` pulse after release.
